// File: rtl/free_reg_list_pkg.sv
// Shared processor parameters used by the rename free list.
package free_reg_list_pkg;

    // Free-list geometry and physical register address width.
    localparam int FRL_DEPTH_DEF  = 32;
    localparam int PHY_ADDR_W_DEF = 6;

    // ROB pointer width and number of architectural registers.
    localparam int ROB_PTR_W      = 5;
    localparam int ARCH_REG_CNT   = 32;

    // Physical register held by free-list slot idx after reset.
    // The first ARCH_REG_CNT physical registers back the architectural
    // state, so the free list starts just above them.
    function automatic int resetPhyAddr(input int idx);
        return ARCH_REG_CNT + idx;
    endfunction

endpackage

// File: rtl/free_reg_list.sv
// Rename free list: a circular FIFO of free physical register addresses.
// Dispatch pops from the head and commit pushes released registers at the
// tail. On a branch flush, head rolls back to a checkpoint so that registers
// allocated on the wrong path are reclaimed in their original order.
module free_reg_list
    import free_reg_list_pkg::*;
#(
    parameter int FRL_DEPTH  = FRL_DEPTH_DEF,
    parameter int PHY_ADDR_W = PHY_ADDR_W_DEF,
    localparam int PTR_W     = $clog2(FRL_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  Dis_FrlRead,
    output logic [PHY_ADDR_W-1:0] Frl_RdPhyAddr,
    output logic                  Frl_Empty,
    input  logic                  Rob_Commit,
    input  logic                  Rob_CommitRegWrite,
    input  logic [PHY_ADDR_W-1:0] Rob_CommitPrePhyAddr,
    output logic [PTR_W-1:0]      Frl_HeadPtr,
    input  logic                  Cdb_Flush,
    input  logic [PTR_W-1:0]      Cfc_FrlHeadPtr,
    output logic [CNT_W-1:0]      Frl_Count
);

    logic [PHY_ADDR_W-1:0] entries [FRL_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  full;
    logic                  popEn;
    logic                  pushReq;
    logic                  pushEn;
    logic [PTR_W-1:0]      restoreDist;

    // Head entry is read without latency so dispatch can rename this cycle.
    assign Frl_RdPhyAddr = entries[head];
    assign Frl_HeadPtr   = head;
    assign Frl_Count     = count;
    assign Frl_Empty     = (count == '0);
    assign full          = (count == CNT_W'(FRL_DEPTH));

    // A flush cancels dispatch, so no pop can happen in a flush cycle.
    assign popEn   = Dis_FrlRead & ~Frl_Empty & ~Cdb_Flush;
    assign pushReq = Rob_Commit & Rob_CommitRegWrite;
    // A push into a full list is accepted only when a pop frees a slot in
    // the same cycle; otherwise it would overwrite a live entry.
    assign pushEn  = pushReq & (~full | popEn);

    // Entries popped since the checkpoint; wraps naturally modulo depth.
    // A distance of zero means nothing was allocated after the branch.
    assign restoreDist = head - Cfc_FrlHeadPtr;

    // Pointer, count and entry array update with asynchronous reset.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FRL_DEPTH);
            for (int i = 0; i < FRL_DEPTH; i++) begin
                entries[i] <= PHY_ADDR_W'(resetPhyAddr(i));
            end
        end else begin
            if (pushEn) begin
                entries[tail] <= Rob_CommitPrePhyAddr;
                tail          <= tail + 1'b1;
            end
            if (Cdb_Flush) begin
                // Entries between the checkpoint and the old head are left
                // untouched, so rolling head back re-exposes them in order.
                head  <= Cfc_FrlHeadPtr;
                count <= count + {1'b0, restoreDist} + CNT_W'(pushEn);
            end else begin
                if (popEn) begin
                    head <= head + 1'b1;
                end
                count <= count + CNT_W'(pushEn) - CNT_W'(popEn);
            end
        end
    end

endmodule

// File: tb/tb_free_reg_list.sv
// Directed bench for free_reg_list. Stimulus pushes the expected outputs
// into a queue; a separate monitor pops and compares them against the DUT.
module tb_free_reg_list;

    logic       clk;
    logic       resetb;
    logic       Dis_FrlRead;
    logic [5:0] Frl_RdPhyAddr;
    logic       Frl_Empty;
    logic       Rob_Commit;
    logic       Rob_CommitRegWrite;
    logic [5:0] Rob_CommitPrePhyAddr;
    logic [4:0] Frl_HeadPtr;
    logic       Cdb_Flush;
    logic [4:0] Cfc_FrlHeadPtr;
    logic [5:0] Frl_Count;

    typedef struct {
        string      name;
        logic [5:0] addr;
        logic       empty;
        logic [4:0] head;
        logic [5:0] cnt;
    } exp_t;

    exp_t expQ[$];
    event expEv;
    int   errors = 0;
    int   checks = 0;

    free_reg_list dut (
        .clk                  (clk),
        .resetb               (resetb),
        .Dis_FrlRead          (Dis_FrlRead),
        .Frl_RdPhyAddr        (Frl_RdPhyAddr),
        .Frl_Empty            (Frl_Empty),
        .Rob_Commit           (Rob_Commit),
        .Rob_CommitRegWrite   (Rob_CommitRegWrite),
        .Rob_CommitPrePhyAddr (Rob_CommitPrePhyAddr),
        .Frl_HeadPtr          (Frl_HeadPtr),
        .Cdb_Flush            (Cdb_Flush),
        .Cfc_FrlHeadPtr       (Cfc_FrlHeadPtr),
        .Frl_Count            (Frl_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushExp(input string nm, input logic [5:0] a, input logic e,
                           input logic [4:0] h, input logic [5:0] c);
        exp_t x;
        x.name = nm; x.addr = a; x.empty = e; x.head = h; x.cnt = c;
        expQ.push_back(x);
        ->expEv;
    endtask

    // One clock of stimulus followed by the expected post-edge outputs.
    task automatic step(input string nm, input logic rd, input logic push,
                        input logic [5:0] pre, input logic fl, input logic [4:0] cfc,
                        input logic [5:0] eA, input logic eE, input logic [4:0] eH,
                        input logic [5:0] eC);
        @(negedge clk);
        Dis_FrlRead          = rd;
        Rob_Commit           = push;
        Rob_CommitRegWrite   = push;
        Rob_CommitPrePhyAddr = pre;
        Cdb_Flush            = fl;
        Cfc_FrlHeadPtr       = cfc;
        @(posedge clk);
        #1;
        pushExp(nm, eA, eE, eH, eC);
    endtask

    task automatic idleInputs;
        Dis_FrlRead          = 1'b0;
        Rob_Commit           = 1'b0;
        Rob_CommitRegWrite   = 1'b0;
        Rob_CommitPrePhyAddr = '0;
        Cdb_Flush            = 1'b0;
        Cfc_FrlHeadPtr       = '0;
    endtask

    task automatic doReset;
        @(negedge clk);
        idleInputs();
        resetb = 1'b0;
        #1;
        pushExp("reset", 6'd32, 1'b0, 5'd0, 6'd32);
        @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic chk(input string nm, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, field, act, req);
        end
    endtask

    // Monitor: compare every queued expectation shortly after it is posted.
    initial begin
        exp_t x;
        forever begin
            @(expEv);
            #1;
            while (expQ.size() > 0) begin
                x = expQ.pop_front();
                chk(x.name, "addr",  int'(Frl_RdPhyAddr), int'(x.addr));
                chk(x.name, "empty", int'(Frl_Empty),     int'(x.empty));
                chk(x.name, "head",  int'(Frl_HeadPtr),   int'(x.head));
                chk(x.name, "count", int'(Frl_Count),     int'(x.cnt));
            end
        end
    end

    initial begin
        resetb = 1'b1;
        idleInputs();
        doReset();

        // Push while full without a pop is dropped.
        step("fullPush", 0, 1, 6'd7, 0, 0, 6'd32, 0, 5'd0, 6'd32);

        // Drain all 32 entries in order.
        for (int i = 0; i < 32; i++) begin
            step("popAll", 1, 0, 0, 0, 0,
                 (i == 31) ? 6'd32 : 6'(33 + i), (i == 31), 5'((i + 1) % 32), 6'(31 - i));
        end
        // Read while empty is ignored; entry 0 was not overwritten above.
        step("popEmpty", 1, 0, 0, 0, 0, 6'd32, 1, 5'd0, 6'd0);

        // Pop and push together from full.
        doReset();
        step("popPush", 1, 1, 6'd5, 0, 0, 6'd33, 0, 5'd1, 6'd32);

        // Checkpoint at head 3, pop 4 more, flush back.
        step("pop2a", 1, 0, 0, 0, 0, 6'd34, 0, 5'd2, 6'd31);
        step("pop2b", 1, 0, 0, 0, 0, 6'd35, 0, 5'd3, 6'd30);
        step("pop4a", 1, 0, 0, 0, 0, 6'd36, 0, 5'd4, 6'd29);
        step("pop4b", 1, 0, 0, 0, 0, 6'd37, 0, 5'd5, 6'd28);
        step("pop4c", 1, 0, 0, 0, 0, 6'd38, 0, 5'd6, 6'd27);
        step("pop4d", 1, 0, 0, 0, 0, 6'd39, 0, 5'd7, 6'd26);
        step("flush3", 0, 0, 0, 1, 5'd3, 6'd35, 0, 5'd3, 6'd30);

        // Read during flush does not pop.
        step("popC", 1, 0, 0, 0, 0, 6'd36, 0, 5'd4, 6'd29);
        step("popD", 1, 0, 0, 0, 0, 6'd37, 0, 5'd5, 6'd28);
        step("flushRd", 1, 0, 0, 1, 5'd3, 6'd35, 0, 5'd3, 6'd30);

        // Mid-stream reset takes effect without a clock edge.
        @(negedge clk);
        Dis_FrlRead          = 1'b1;
        Rob_Commit           = 1'b1;
        Rob_CommitRegWrite   = 1'b1;
        Rob_CommitPrePhyAddr = 6'd9;
        @(posedge clk);
        #3;
        resetb = 1'b0;
        #1;
        pushExp("asyncRst", 6'd32, 0, 5'd0, 6'd32);
        @(posedge clk);
        #1;
        pushExp("rstHold", 6'd32, 0, 5'd0, 6'd32);
        @(negedge clk);
        idleInputs();
        resetb = 1'b1;

        // Wrapped flush from head 2 back to 30 together with a push.
        doReset();
        for (int i = 0; i < 30; i++) begin
            step("pop30", 1, 0, 0, 0, 0, 6'(33 + i), 0, 5'(i + 1), 6'(31 - i));
        end
        step("wrapA", 1, 1, 6'd10, 0, 0, 6'd63, 0, 5'd31, 6'd2);
        step("wrapB", 1, 1, 6'd11, 0, 0, 6'd10, 0, 5'd0,  6'd2);
        step("wrapC", 1, 1, 6'd12, 0, 0, 6'd11, 0, 5'd1,  6'd2);
        step("wrapD", 1, 1, 6'd13, 0, 0, 6'd12, 0, 5'd2,  6'd2);
        step("flush30", 0, 1, 6'd20, 1, 5'd30, 6'd62, 0, 5'd30, 6'd7);
        // Reclaimed entries come back in their original order.
        step("reclA", 1, 0, 0, 0, 0, 6'd63, 0, 5'd31, 6'd6);
        step("reclB", 1, 0, 0, 0, 0, 6'd10, 0, 5'd0,  6'd5);
        step("reclC", 1, 0, 0, 0, 0, 6'd11, 0, 5'd1,  6'd4);
        step("reclD", 1, 0, 0, 0, 0, 6'd12, 0, 5'd2,  6'd3);
        step("reclE", 1, 0, 0, 0, 0, 6'd13, 0, 5'd3,  6'd2);
        step("reclF", 1, 0, 0, 0, 0, 6'd20, 0, 5'd4,  6'd1);
        step("reclG", 1, 0, 0, 0, 0, 6'd37, 1, 5'd5,  6'd0);

        @(negedge clk);
        idleInputs();
        #5;
        if (expQ.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/free_reg_list.md
FREE_REG_LIST -- requirements
Module: free_reg_list

Interface
REQ-001 SHALL have parameter FRL_DEPTH, default 32, meaning the number of free-list entries (power of two).
REQ-002 SHALL have parameter PHY_ADDR_W, default 6, meaning the physical register address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port resetb, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port Dis_FrlRead, input, 1 bit: dispatch consumes the head entry this cycle.
REQ-006 SHALL have port Frl_RdPhyAddr, output, 6 bits: the free physical address at the head.
REQ-007 SHALL have port Frl_Empty, output, 1 bit: no free register is available.
REQ-008 SHALL have port Rob_Commit, input, 1 bit: the ROB commits an instruction this cycle.
REQ-009 SHALL have port Rob_CommitRegWrite, input, 1 bit: the committing instruction writes a register.
REQ-010 SHALL have port Rob_CommitPrePhyAddr, input, 6 bits: the previous Rd physical address, released on commit.
REQ-011 SHALL have port Frl_HeadPtr, output, 5 bits: the current head pointer, sampled by the checkpoint unit when a branch dispatches.
REQ-012 SHALL have port Cdb_Flush, input, 1 bit: branch misprediction flush.
REQ-013 SHALL have port Cfc_FrlHeadPtr, input, 5 bits: the head pointer to restore on flush.
REQ-014 SHALL have port Frl_Count, output, 6 bits: the number of valid free entries (0..32).

Function
REQ-015 SHALL implement a 32-entry circular FIFO of 6-bit physical addresses with 5-bit head/tail pointers and a 6-bit count.
REQ-016 SHALL drive Frl_RdPhyAddr combinationally from the entry at head (zero-latency read) and Frl_HeadPtr = head.
REQ-017 SHALL drive Frl_Empty = (count == 0).
REQ-018 SHALL define pop = Dis_FrlRead & !Frl_Empty & !Cdb_Flush; a pop advances head by 1 (mod 32).
REQ-019 SHALL define push = Rob_Commit & Rob_CommitRegWrite; a push writes Rob_CommitPrePhyAddr at tail and advances tail by 1 (mod 32).
REQ-020 SHALL ignore Dis_FrlRead when Frl_Empty=1: head and count are unchanged.
REQ-021 SHALL, on pop and push in the same cycle, update both pointers and leave count unchanged.
REQ-022 SHALL, on Cdb_Flush, load head <= Cfc_FrlHeadPtr and set count <= count + ((head - Cfc_FrlHeadPtr) mod 32) + push.
REQ-023 SHALL treat a restore distance of 0 as no entries reclaimed (at most 31 pops can follow a checkpointed branch in a 32-entry ROB).
REQ-024 SHALL let a commit push in the flush cycle complete normally (tail advance, entry write); Dis_FrlRead is ignored in a flush cycle.
REQ-025 SHALL keep entries between the restored head and the old head unmodified, so reclaimed addresses reappear in original order.
REQ-026 SHALL ignore a push when count == 32 (protocol violation) and leave all state unchanged for that push.
REQ-027 SHALL wrap pointers from 31 to 0 without bubbles.

Reset
REQ-028 SHALL on resetb=0 asynchronously set head=0, tail=0, count=32, and entry[i]=32+i for i=0..31.
REQ-029 SHALL produce reset outputs Frl_RdPhyAddr=32, Frl_Empty=0, Frl_HeadPtr=0, Frl_Count=32.
REQ-030 SHALL abandon any in-flight pop, push or flush when reset is asserted, with the reset values taking priority.

Structure
REQ-031 SHALL take FRL_DEPTH, PHY_ADDR_W, the ROB pointer width (5) and the architectural register count (32) from the shared processor package.
REQ-032 SHALL be a single module with no sub-module; the entry array is a distributed register array with one write and one asynchronous read port.

Verification
REQ-033 Verification SHALL cover reset followed by 32 pops with Dis_FrlRead=1 -> addresses 32..63 in order, then Frl_Empty=1 and Frl_Count=0; a 33rd read leaves head=0.
REQ-034 Verification SHALL cover, from reset, push of 5 in the same cycle as a pop -> Frl_RdPhyAddr goes 32->33 and count stays 32-1+1=32.
REQ-035 Verification SHALL cover sampling Frl_HeadPtr=3, popping 4 more (head=7), then Cdb_Flush with Cfc_FrlHeadPtr=3 -> head=3, count +4, Frl_RdPhyAddr=35.
REQ-036 Verification SHALL cover flush with Cfc_FrlHeadPtr=30 while head=2 (wrapped) concurrent with push -> head=30 and count increases by 4+1=5.
REQ-037 Verification SHALL cover Dis_FrlRead=1 during Cdb_Flush -> no pop and head equals Cfc_FrlHeadPtr.
REQ-038 Verification SHALL cover asserting resetb=0 mid-stream -> all outputs return to reset values immediately, without waiting for a clock edge.
